i2c_rx_byte_ctrl: RTL and testbench

- Sequences the I2C receive path: counts SCL sample strobes, shifts SDA into an 8-bit shift register, then drives the ACK/NACK bit.
- Hands each completed byte to the APB-side RX buffer over a valid/ready handshake.
- Sits between the SCL/SDA edge detector and the RX FIFO; serves both master-read and slave-write.
- Stretches SCL when the output holding register is still occupied.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_rx_shift8.sv | 21 ++
 rtl/i2c_rx_byte_ctrl.sv | 166 ++++++++++++++++
 tb/tb_i2c_rx_byte_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C receive path.
package i2c_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned BIT_CNT_W     = $clog2(BITS_PER_BYTE);
    localparam bit          ACK_LVL_DEF   = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        LOAD    = 3'd2,
        ACK_DRV = 3'd3,
        ACK_REL = 3'd4
    } rx_state_t;

endpackage

// File: rtl/i2c_rx_shift8.sv
// 8-bit MSB-first receive shift register with synchronous clear and parallel out.
module i2c_rx_shift8
    import i2c_pkg::*;
(
    input  logic                     i2c_clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     shift_en,
    input  logic                     sda_in,
    output logic [BITS_PER_BYTE-1:0] data
);

    always_ff @(posedge i2c_clk) begin
        if (rst || clear) begin
            data <= '0;
        end else if (shift_en) begin
            data <= {data[BITS_PER_BYTE-2:0], sda_in};
        end
    end

endmodule

// File: rtl/i2c_rx_byte_ctrl.sv
// I2C receive byte sequencer: samples SDA on SCL rises, hands each byte to the RX
// buffer over valid/ready, drives ACK/NACK and stretches SCL while the buffer is full.
module i2c_rx_byte_ctrl
    import i2c_pkg::*;
#(
    parameter bit STRETCH_EN = 1'b1,
    parameter bit ACK_LVL    = ACK_LVL_DEF
) (
    input  logic                     i2c_clk,
    input  logic                     rst,
    input  logic                     rx_en,
    input  logic                     ack_en,
    input  logic                     start_det,
    input  logic                     stop_det,
    input  logic                     scl_rise,
    input  logic                     scl_fall,
    input  logic                     sda_in,
    output logic [BITS_PER_BYTE-1:0] byte_data,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     sda_oe,
    output logic                     scl_hold,
    output logic [BIT_CNT_W-1:0]     bit_cnt,
    output logic                     busy,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    rx_state_t                state, state_nx;
    logic [BIT_CNT_W-1:0]     bit_cnt_nx;
    logic [BITS_PER_BYTE-1:0] byte_data_nx, shreg;
    logic                     byte_valid_nx, sda_oe_nx, scl_hold_nx, overflow_nx;
    logic                     ack_bit, ack_bit_nx;
    logic                     fall_pend, fall_pend_nx;
    logic                     ack_done, ack_done_nx;
    logic                     shift_en_c, clear_c, hold_free_c, fall_seen_c;

    // The pad only ever pulls toward ACK_LVL; the enable polarity does not depend on it.
    logic ack_lvl_unused;
    assign ack_lvl_unused = ACK_LVL;

    i2c_rx_shift8 u_shift (
        .i2c_clk  (i2c_clk),
        .rst      (rst),
        .clear    (clear_c),
        .shift_en (shift_en_c),
        .sda_in   (sda_in),
        .data     (shreg)
    );

    assign hold_free_c = !byte_valid || byte_ready;
    assign fall_seen_c = fall_pend || scl_fall;

    always_comb begin
        state_nx      = state;
        bit_cnt_nx    = bit_cnt;
        byte_data_nx  = byte_data;
        byte_valid_nx = byte_valid && !byte_ready;
        sda_oe_nx     = sda_oe;
        scl_hold_nx   = 1'b0;
        overflow_nx   = overflow && !ovf_clr;
        ack_bit_nx    = ack_bit;
        fall_pend_nx  = fall_pend;
        ack_done_nx   = ack_done;
        shift_en_c    = 1'b0;
        clear_c       = 1'b0;

        if (stop_det) begin
            state_nx     = IDLE;
            bit_cnt_nx   = '0;
            sda_oe_nx    = 1'b0;
            fall_pend_nx = 1'b0;
            ack_done_nx  = 1'b0;
        end else if (start_det && (state != IDLE || rx_en)) begin
            state_nx     = SHIFT;
            bit_cnt_nx   = '0;
            sda_oe_nx    = 1'b0;
            fall_pend_nx = 1'b0;
            ack_done_nx  = 1'b0;
            clear_c      = 1'b1;
        end else begin
            unique case (state)
                IDLE: ;
                SHIFT: begin
                    if (scl_rise) begin
                        shift_en_c = 1'b1;
                        bit_cnt_nx = bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == BIT_CNT_W'(BITS_PER_BYTE - 1)) begin
                            state_nx     = LOAD;
                            fall_pend_nx = 1'b0;
                        end
                    end
                end
                LOAD: begin
                    // A fall seen while waiting here is the ACK change point; drive on exit.
                    if (hold_free_c || !STRETCH_EN) begin
                        state_nx     = ACK_DRV;
                        ack_bit_nx   = hold_free_c && ack_en;
                        ack_done_nx  = fall_seen_c;
                        fall_pend_nx = 1'b0;
                        if (fall_seen_c) begin
                            sda_oe_nx = hold_free_c && ack_en;
                        end
                        if (hold_free_c) begin
                            byte_data_nx  = shreg;
                            byte_valid_nx = 1'b1;
                        end else begin
                            overflow_nx = 1'b1;
                        end
                    end else begin
                        scl_hold_nx  = 1'b1;
                        fall_pend_nx = fall_seen_c;
                    end
                end
                ACK_DRV: begin
                    if (!ack_done) begin
                        if (scl_fall) begin
                            sda_oe_nx   = ack_bit;
                            ack_done_nx = 1'b1;
                        end
                    end else if (scl_rise) begin
                        state_nx = ACK_REL;
                    end
                end
                ACK_REL: begin
                    if (scl_fall) begin
                        sda_oe_nx   = 1'b0;
                        ack_done_nx = 1'b0;
                        bit_cnt_nx  = '0;
                        state_nx    = ack_bit ? SHIFT : IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge i2c_clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            sda_oe     <= 1'b0;
            scl_hold   <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            ack_bit    <= 1'b0;
            fall_pend  <= 1'b0;
            ack_done   <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            byte_data  <= byte_data_nx;
            byte_valid <= byte_valid_nx;
            sda_oe     <= sda_oe_nx;
            scl_hold   <= scl_hold_nx;
            busy       <= (state_nx != IDLE);
            overflow   <= overflow_nx;
            ack_bit    <= ack_bit_nx;
            fall_pend  <= fall_pend_nx;
            ack_done   <= ack_done_nx;
        end
    end

endmodule

// File: tb/tb_i2c_rx_byte_ctrl.sv
// Directed bench for i2c_rx_byte_ctrl: a byte-order scoreboard plus expected ACK/busy
// levels checked every cycle, and hand-computed checks at stretch/overflow/reset points.
module tb_i2c_rx_byte_ctrl;

    logic       i2c_clk, rst, rx_en, ack_en, start_det, stop_det;
    logic       scl_rise, scl_fall, sda_in, byte_ready, ovf_clr;

    logic [7:0] s_byte_data, n_byte_data;
    logic       s_byte_valid, n_byte_valid, s_sda_oe, n_sda_oe, s_scl_hold, n_scl_hold;
    logic [2:0] s_bit_cnt, n_bit_cnt;
    logic       s_busy, n_busy, s_overflow, n_overflow;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_front;
    logic       exp_sda, exp_busy, chk_en;

    i2c_rx_byte_ctrl #(.STRETCH_EN(1'b1)) u_dut (
        .i2c_clk(i2c_clk), .rst(rst), .rx_en(rx_en), .ack_en(ack_en),
        .start_det(start_det), .stop_det(stop_det), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .sda_in(sda_in), .byte_data(s_byte_data), .byte_valid(s_byte_valid),
        .byte_ready(byte_ready), .sda_oe(s_sda_oe), .scl_hold(s_scl_hold),
        .bit_cnt(s_bit_cnt), .busy(s_busy), .overflow(s_overflow), .ovf_clr(ovf_clr)
    );

    i2c_rx_byte_ctrl #(.STRETCH_EN(1'b0)) u_dut_ns (
        .i2c_clk(i2c_clk), .rst(rst), .rx_en(rx_en), .ack_en(ack_en),
        .start_det(start_det), .stop_det(stop_det), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .sda_in(sda_in), .byte_data(n_byte_data), .byte_valid(n_byte_valid),
        .byte_ready(byte_ready), .sda_oe(n_sda_oe), .scl_hold(n_scl_hold),
        .bit_cnt(n_bit_cnt), .busy(n_busy), .overflow(n_overflow), .ovf_clr(ovf_clr)
    );

    initial begin
        i2c_clk = 1'b0;
        forever #5 i2c_clk = ~i2c_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the scoreboard and the expected ACK/busy levels.
    task automatic cycle_compare();
        assert (!(scl_rise && scl_fall)) else $error("scl_rise and scl_fall together");
        if (!chk_en) return;
        if (s_byte_valid && byte_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL spurious_byte: got 0x%0h, expected no byte", s_byte_data);
            end else begin
                exp_front = exp_q.pop_front();
                if (s_byte_data !== exp_front) begin
                    fails++;
                    $display("FAIL rx_byte: got 0x%0h, expected 0x%0h", s_byte_data, exp_front);
                end
            end
        end
        check("sda_oe_cycle", s_sda_oe, exp_sda);
        check("busy_cycle", s_busy, exp_busy);
    endtask

    task automatic tick();
        @(negedge i2c_clk);
        cycle_compare();
        @(posedge i2c_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start(); start_det = 1'b1; tick(); start_det = 1'b0; endtask
    task automatic pulse_stop();  stop_det  = 1'b1; tick(); stop_det  = 1'b0; endtask
    task automatic pulse_rise();  scl_rise  = 1'b1; tick(); scl_rise  = 1'b0; endtask
    task automatic pulse_fall();  scl_fall  = 1'b1; tick(); scl_fall  = 1'b0; endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            sda_in = d[7-i];
            pulse_rise();
            idle(2);
            pulse_fall();
            idle(2);
        end
    endtask

    // Full byte plus ACK slot, holding register assumed free when the byte lands.
    task automatic send_byte(input logic [7:0] d, input logic ack, input bit lat);
        exp_q.push_back(d);
        send_bits(d, 7);
        sda_in = d[0];
        pulse_rise();
        if (lat) check("valid_lat1", s_byte_valid, 0);
        tick();
        if (lat) begin
            check("valid_lat2", s_byte_valid, 1);
            check("data_lat2", s_byte_data, d);
        end
        tick();
        if (lat) check("valid_pulse_end", s_byte_valid, 0);
        pulse_fall();
        exp_sda = ack;
        idle(2);
        pulse_rise();
        idle(2);
        pulse_fall();
        exp_sda = 1'b0;
        if (!ack) exp_busy = 1'b0;
        idle(2);
    endtask

    initial begin
        rst = 1'b1; rx_en = 1'b0; ack_en = 1'b1; start_det = 1'b0; stop_det = 1'b0;
        scl_rise = 1'b0; scl_fall = 1'b0; sda_in = 1'b1; byte_ready = 1'b1; ovf_clr = 1'b0;
        chk_en = 1'b0; exp_sda = 1'b0; exp_busy = 1'b0;
        @(posedge i2c_clk); #1;
        idle(3);
        check("rst_byte_data", s_byte_data, 0);
        check("rst_byte_valid", s_byte_valid, 0);
        check("rst_sda_oe", s_sda_oe, 0);
        check("rst_scl_hold", s_scl_hold, 0);
        check("rst_bit_cnt", s_bit_cnt, 0);
        check("rst_busy", s_busy, 0);
        check("rst_overflow", s_overflow, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // START ignored while receive is disabled
        pulse_start();
        idle(2);
        check("rx_dis_busy", s_busy, 0);
        rx_en = 1'b1;

        // Single ACKed byte 0xA5
        pulse_start();
        exp_busy = 1'b1;
        check("start_bit_cnt", s_bit_cnt, 0);
        send_byte(8'hA5, 1'b1, 1'b1);
        check("after_ack_busy", s_busy, 1);
        check("after_ack_bit_cnt", s_bit_cnt, 0);

        // Two bytes, the second NACKed
        send_byte(8'h3C, 1'b1, 1'b0);
        ack_en = 1'b0;
        send_byte(8'h81, 1'b0, 1'b0);
        ack_en = 1'b1;
        check("nack_busy", s_busy, 0);
        check("q_empty_1", exp_q.size(), 0);

        // Stretch while the holding register is still occupied
        byte_ready = 1'b0;
        pulse_start();
        exp_busy = 1'b1;
        send_byte(8'h11, 1'b1, 1'b0);
        send_bits(8'h22, 7);
        sda_in = 1'b0;
        pulse_rise();
        tick();
        check("stretch_hold", s_scl_hold, 1);
        pulse_fall();
        idle(2);
        check("stretch_hold_kept", s_scl_hold, 1);
        check("stretch_data_kept", s_byte_data, 8'h11);
        exp_q.push_back(8'h22);
        byte_ready = 1'b1;
        tick();
        exp_sda = 1'b1;
        check("stretch_release", s_scl_hold, 0);
        check("stretch_new_data", s_byte_data, 8'h22);
        check("stretch_ack", s_sda_oe, 1);
        idle(2);
        pulse_rise();
        idle(2);
        pulse_fall();
        exp_sda = 1'b0;
        idle(2);
        pulse_stop();
        exp_busy = 1'b0;
        idle(1);
        check("q_empty_2", exp_q.size(), 0);

        // No-stretch instance: second byte dropped and NACKed, first retained
        chk_en = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        byte_ready = 1'b0;
        pulse_start();
        send_bits(8'h5A, 8);
        idle(2);
        check("ns_first_ack", n_sda_oe, 1);
        pulse_rise(); idle(2); pulse_fall(); idle(2);
        check("ns_first_data", n_byte_data, 8'h5A);
        check("ns_first_valid", n_byte_valid, 1);
        check("ns_no_ovf_yet", n_overflow, 0);
        send_bits(8'hC3, 7);
        sda_in = 1'b1;
        pulse_rise();
        tick();
        check("ns_overflow", n_overflow, 1);
        check("ns_no_hold", n_scl_hold, 0);
        check("ns_data_kept", n_byte_data, 8'h5A);
        idle(1);
        pulse_fall();
        idle(1);
        check("ns_nack", n_sda_oe, 0);
        check("ns_busy_ack", n_busy, 1);
        pulse_rise(); idle(1); pulse_fall(); idle(1);
        check("ns_idle", n_busy, 0);
        check("ns_valid_kept", n_byte_valid, 1);
        check("ns_ovf_sticky", n_overflow, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ns_ovf_clr", n_overflow, 0);

        rst = 1'b1; byte_ready = 1'b1; tick(); rst = 1'b0;
        exp_q.delete(); exp_sda = 1'b0; exp_busy = 1'b0;
        chk_en = 1'b1;

        // STOP after 4 bits
        pulse_start();
        exp_busy = 1'b1;
        send_bits(8'hF0, 4);
        check("stop_pre_cnt", s_bit_cnt, 4);
        pulse_stop();
        exp_busy = 1'b0;
        check("stop_bit_cnt", s_bit_cnt, 0);
        check("stop_no_valid", s_byte_valid, 0);
        idle(3);

        // Repeated START after 5 bits, then a clean byte
        pulse_start();
        exp_busy = 1'b1;
        send_bits(8'hFF, 5);
        check("rs_pre_cnt", s_bit_cnt, 5);
        pulse_start();
        check("rs_bit_cnt", s_bit_cnt, 0);
        send_byte(8'h6D, 1'b1, 1'b1);
        pulse_stop();
        exp_busy = 1'b0;
        idle(1);
        check("q_empty_3", exp_q.size(), 0);

        // Reset during ACK_DRV
        chk_en = 1'b0;
        byte_ready = 1'b0;
        pulse_start();
        send_bits(8'h99, 8);
        idle(1);
        check("pre_rst_sda", s_sda_oe, 1);
        check("pre_rst_valid", s_byte_valid, 1);
        check("pre_rst_data", s_byte_data, 8'h99);
        rst = 1'b1;
        tick();
        check("midrst_sda", s_sda_oe, 0);
        check("midrst_valid", s_byte_valid, 0);
        check("midrst_busy", s_busy, 0);
        check("midrst_data", s_byte_data, 0);
        rst = 1'b0;
        byte_ready = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
